pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
// - Parametrised elastic pipeline register for inter-stage boundaries (if_id, id_ex, ex_mem, ...).
// - Carries one packed payload bus with a valid/ready handshake in place of a bare enable.
// - Keeps the ctrl-driven flush/stall semantics: flush loads a NOP payload, stall freezes the stage.
// - With SKID=1, an optional 2-entry skid buffer gives full throughput with a registered in_ready_o.
// PARAMETERS
// - WIDTH    64  payload width in bits; packed {inst, inst_addr, op1, op2, ...}; must be >= 1
// - NOP_VAL  0   WIDTH-bit payload driven after reset/flush; id_ex places `INST_NOP in the inst field
// - SKID     1   1: 2-entry skid buffer, registered in_ready_o; 0: single register, combinational ready
// PORTS
// - clk          in   1      system clock; all state updates on posedge
// - rst          in   1      reset; asynchronous, active-high
// - flush_i      in   1      from ctrl; synchronous squash of all held entries
// - stall_i      in   1      from ctrl; freezes the stage; no transfer on either side
// - in_valid_i   in   1      upstream payload valid
// - in_ready_o   out  1      stage can accept a payload this cycle
// - in_data_i    in   WIDTH  upstream payload
// - out_valid_o  out  1      out_data_o holds a live payload
// - out_ready_i  in   1      downstream accepts out_data_o this cycle
// - out_data_o   out  WIDTH  registered payload to the next stage
// - occ_o        out  2      entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
// - Reset: out_valid_o=0, out_data_o=NOP_VAL, occ_o=0, skid entry invalid.
//   in_ready_o=1 immediately on reset assertion (gated by stall_i).
// - in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
//   Both fire terms are forced 0 while stall_i=1.
// - stall_i=1: in_ready_o=0 and out_valid_o=0 (combinational gating); all registers hold.
//   Data is never lost or duplicated across a stall.
// - flush_i=1 (priority over stall_i and every handshake):
//   - next cycle occ_o=0, out_valid_o=0, out_data_o=NOP_VAL, skid cleared;
//   - any in_fire in the flush cycle is discarded.
// - Latency: an empty stage presents a payload accepted at edge N as out_valid_o=1 after edge N.
//   No combinational in->out path.
// - SKID=1 state machine on occ:
//   - EMPTY(0): in_fire -> ONE; main reg <= in_data_i.
//   - ONE(1):
//     - in_fire & out_fire -> ONE; main reg <= in_data_i.
//     - in_fire & !out_fire -> FULL; skid <= in_data_i.
//     - !in_fire & out_fire -> EMPTY; main reg <= NOP_VAL.
//   - FULL(2): out_fire -> ONE; main reg <= skid. in_fire is impossible in FULL.
//   - in_ready_o = (occ!=2) & !stall_i. The occ term is a flop output: no ready path from out_ready_i.
// - SKID=0: states EMPTY/ONE only.
//   - in_ready_o = (!out_valid_q | out_ready_i) & !stall_i (combinational).
//   - Simultaneous in_fire & out_fire stays in ONE at 1 payload/cycle.
// - Ordering: strict FIFO; the skid entry is always younger than the main entry.
// - Flush mid-FULL: both entries are dropped. Reset mid-transfer: same as flush, but asynchronous.
// - Empty stage: out_data_o=NOP_VAL, so legacy consumers ignoring out_valid_o see a bubble.
// STRUCTURE
// - Shared constants in defines.v: `INST_NOP, plus field offsets/widths of each stage's packed
//   payload (e.g. ID_EX_W). Stages pack/unpack with those macros.
// - One sub-module, pipe_skid_buf (WIDTH): the skid entry register plus its valid bit.
//   Instantiated only under SKID=1 (generate).
// - Main register and occ FSM stay in pipe_stage_hs. id_ex becomes a thin wrapper:
//   pipe_stage_hs #(.WIDTH(ID_EX_W), .SKID(0)).
// TESTING
// - Reset then idle: occ_o=0, out_valid_o=0, out_data_o=NOP_VAL, in_ready_o=1.
//   Assert rst mid-FULL: same values immediately (asynchronous).
// - Streaming, out_ready_i=1, payloads 0x1,0x2,0x3 on consecutive cycles: out_data_o=0x1,0x2,0x3
//   one cycle later, 1/cycle. Check with SKID=0 and SKID=1.
// - SKID=1 backpressure: out_ready_i=0, push 0xA,0xB.
//   - occ_o=2 and in_ready_o=0 on the cycle after 0xB.
//   - Release: out 0xA then 0xB; in_ready_o=1 the cycle after the first pop.
// - Stall: while ONE holding 0x5, hold stall_i=1 for 3 cycles with in_valid_i=1 (0x6).
//   - in_ready_o=0 and out_valid_o=0 throughout; occ_o stays 1.
//   - After release: 0x5, then 0x6.
// - Flush: in FULL (0xA,0xB), assert flush_i with in_valid_i=1 (0xC) and stall_i=1.
//   - Next cycle: occ_o=0, out_data_o=NOP_VAL; 0xC is never output.
// - Random valid/ready/stall with rare flush, 10k cycles: the output sequence equals the scoreboard.
//   Scoreboard model: enqueue on in_fire, dequeue on out_fire, clear on flush.
//   Also check: no drop/duplicate, occ_o<=2, and SKID=1 in_ready_o has no path from out_ready_i.

Source files
------------

// File: rtl/pipe_stage_hs_pkg.sv
// Shared types and occupancy encodings for the elastic pipeline stage.
package pipe_stage_hs_pkg;

  typedef logic [1:0] occ_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single skid entry: a payload register plus its valid bit, younger than the main entry.
module pipe_skid_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] next,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // NOTE: the payload flops carry no reset; valid alone decides whether the content matters.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= next;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic pipeline register with valid/ready handshake, ctrl flush/stall and optional skid entry.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] NOP_VAL = '0,
  parameter bit               SKID    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occ_o
);

  occ_t             occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid, skid_load, skid_clear;
  logic             room, in_fire, out_fire;

  generate
    if (SKID) begin : g_skid
      // Room depends only on a flop, so in_ready_o never sees out_ready_i.
      assign room = ~skid_valid;

      pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .next  (in_data_i),
        .valid (skid_valid),
        .data  (skid_data)
      );
    end else begin : g_no_skid
      assign room       = (occ_q == OCC_EMPTY) | out_ready_i;
      assign skid_valid = 1'b0;
      assign skid_data  = NOP_VAL;
    end
  endgenerate

  assign in_ready_o  = room & ~stall_i;
  assign out_valid_o = (occ_q != OCC_EMPTY) & ~stall_i;
  assign out_data_o  = main_q;
  assign occ_o       = occ_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    occ_d      = occ_q;
    main_d     = main_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush_i) begin
      occ_d      = OCC_EMPTY;
      main_d     = NOP_VAL;
      skid_clear = 1'b1;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            occ_d  = OCC_ONE;
            main_d = in_data_i;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            occ_d     = OCC_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            occ_d  = OCC_EMPTY;
            main_d = NOP_VAL;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            occ_d      = OCC_ONE;
            main_d     = skid_data;
            skid_clear = 1'b1;
          end
        end
        default: begin
          occ_d      = OCC_EMPTY;
          main_d     = NOP_VAL;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= NOP_VAL;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and scoreboard-checked bench driving a SKID=1 and a SKID=0 stage in parallel.
module tb_pipe_stage_hs;

  localparam int          W   = 16;
  localparam logic [15:0] NOP = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, stall = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0]  out_data1, out_data0;
  logic [1:0]    occ1, occ0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(W), .NOP_VAL(NOP), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_data_i(in_data),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_data_o(out_data1),
    .occ_o(occ1)
  );

  pipe_stage_hs #(.WIDTH(W), .NOP_VAL(NOP), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready0), .in_data_i(in_data),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_data_o(out_data0),
    .occ_o(occ0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  initial begin
    // Reset then idle
    #2 rst = 1'b1;
    #1;
    check("rst_occ1", occ1, 0);
    check("rst_valid1", out_valid1, 0);
    check("rst_data1", out_data1, NOP);
    check("rst_ready1", in_ready1, 1);
    check("rst_occ0", occ0, 0);
    check("rst_ready0", in_ready0, 1);
    tick();
    rst = 1'b0;
    tick();

    // Streaming 1,2,3 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push(W'(i));
      check("str_valid1", out_valid1, 1);
      check("str_data1", out_data1, i);
      check("str_valid0", out_valid0, 1);
      check("str_data0", out_data0, i);
      check("str_ready1", in_ready1, 1);
    end
    in_valid = 1'b0;
    tick();
    check("str_end_valid1", out_valid1, 0);
    check("str_end_data1", out_data1, NOP);
    check("str_end_valid0", out_valid0, 0);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    push(16'hA);
    check("bp_occ1_a", occ1, 1);
    push(16'hB);
    check("bp_occ1_full", occ1, 2);
    check("bp_ready1_full", in_ready1, 0);
    check("bp_occ0", occ0, 1);
    check("bp_data0", out_data0, 16'hA);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_pop_a", out_data1, 16'hA);
    check("bp_pop_a_valid", out_valid1, 1);
    tick();
    check("bp_pop_b", out_data1, 16'hB);
    check("bp_ready_after_pop", in_ready1, 1);
    check("bp_occ1_one", occ1, 1);
    tick();
    check("bp_empty1", occ1, 0);
    check("bp_empty0", occ0, 0);

    // Stall while holding 0x5 with 0x6 offered
    out_ready = 1'b0;
    push(16'h5);
    stall   = 1'b1;
    in_data = 16'h6;
    #1;
    check("st_ready1", in_ready1, 0);
    check("st_valid1", out_valid1, 0);
    check("st_ready0", in_ready0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_occ1", occ1, 1);
      check("st_occ0", occ0, 1);
      check("st_ready1_hold", in_ready1, 0);
      check("st_valid1_hold", out_valid1, 0);
      check("st_data1_hold", out_data1, 16'h5);
    end
    stall     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("st_rel_data1", out_data1, 16'h5);
    check("st_rel_valid1", out_valid1, 1);
    tick();
    in_valid = 1'b0;
    check("st_next_data1", out_data1, 16'h6);
    check("st_next_data0", out_data0, 16'h6);
    check("st_next_occ1", occ1, 1);
    tick();
    check("st_drain1", occ1, 0);

    // Flush from FULL with a stalled, valid 0xC on the input
    out_ready = 1'b0;
    push(16'hA);
    push(16'hB);
    check("fl_pre_occ1", occ1, 2);
    flush   = 1'b1;
    stall   = 1'b1;
    in_data = 16'hC;
    tick();
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_occ1", occ1, 0);
    check("fl_data1", out_data1, NOP);
    check("fl_valid1", out_valid1, 0);
    check("fl_occ0", occ0, 0);
    check("fl_data0", out_data0, NOP);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("fl_no_c1", out_valid1, 0);
      check("fl_no_c0", out_valid0, 0);
    end

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    push(16'hA);
    push(16'hB);
    in_valid = 1'b0;
    check("ar_pre_occ1", occ1, 2);
    #2 rst = 1'b1;
    #1;
    check("ar_occ1", occ1, 0);
    check("ar_valid1", out_valid1, 0);
    check("ar_data1", out_data1, NOP);
    check("ar_ready1", in_ready1, 1);
    check("ar_occ0", occ0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Random traffic against a FIFO scoreboard per instance
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic exp_r1, exp_r0;
      flush     = ($urandom_range(0, 99) < 2);
      stall     = ($urandom_range(0, 99) < 15);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      in_data   = W'($urandom);
      exp_r1 = (q1.size() < 2) && !stall;
      #1;
      check("rnd_ready1", in_ready1, exp_r1);
      out_ready = ~out_ready;
      #1;
      check("rnd_ready1_path", in_ready1, exp_r1);
      out_ready = ~out_ready;
      #1;
      exp_r0 = ((q0.size() == 0) || out_ready) && !stall;
      check("rnd_ready0", in_ready0, exp_r0);
      check("rnd_occ1", occ1, q1.size());
      check("rnd_occ0", occ0, q0.size());
      check("rnd_valid1", out_valid1, (q1.size() != 0) && !stall);
      check("rnd_valid0", out_valid0, (q0.size() != 0) && !stall);
      check("rnd_data1", out_data1, (q1.size() != 0) ? q1[0] : NOP);
      check("rnd_data0", out_data0, (q0.size() != 0) ? q0[0] : NOP);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() != 0 && !stall && out_ready) void'(q1.pop_front());
        if (q0.size() != 0 && !stall && out_ready) void'(q0.pop_front());
        if (in_valid && exp_r1) q1.push_back(in_data);
        if (in_valid && exp_r0) q0.push_back(in_data);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
